// File: rtl/ow_scoreboard_chk.sv
// Scoreboard/checker for the 1-Wire master: expected-command FIFO, ROM search
// result checker, STPZ level sampler, sticky error flags and pass/fail verdict.
module ow_scoreboard_chk #(
  parameter int unsigned CMD_W      = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned ROMID_W    = 64,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                          CLK,
  input  logic                          MRZ,
  input  logic                          EXP_VALID,
  input  logic [CMD_W-1:0]              EXP_CMD,
  output logic                          EXP_FULL,
  input  logic                          ACT_VALID,
  input  logic [CMD_W-1:0]              ACT_CMD,
  input  logic [NUM_SLAVES*ROMID_W-1:0] ROMID_TABLE,
  input  logic                          ROMID_START,
  input  logic                          ROMID_VALID,
  input  logic [ROMID_W-1:0]            ROMID_IN,
  input  logic                          STPZ,
  input  logic                          STPZ_CHK,
  input  logic                          STPZ_EXP,
  input  logic                          REPORT_REQ,
  output logic                          PASS_VALID,
  output logic                          PASS,
  output logic [8:0]                    ERR_FLAGS,
  output logic [CNT_W-1:0]              ERR_CNT,
  output logic                          SRCH_BUSY
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned FW = $clog2(NUM_SLAVES + 1);
  localparam logic [AW:0]   FullCnt  = (AW + 1)'(DEPTH);
  localparam logic [FW-1:0] NumSlv   = FW'(NUM_SLAVES);
  localparam logic [1:0]    S_IDLE   = 2'd0;
  localparam logic [1:0]    S_SRCH   = 2'd1;
  localparam logic [1:0]    S_CHECK  = 2'd2;

  logic [CMD_W-1:0]      mem_q [DEPTH];
  logic [AW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, cnt_q, cnt_d;
  logic [1:0]            state_q, state_d;
  logic [NUM_SLAVES-1:0] mask_q, mask_d, sel;
  logic [FW-1:0]         fcnt_q, fcnt_d;
  logic [8:0]            flags_q, flags_d, ev;
  logic [CNT_W-1:0]      errcnt_q, errcnt_d;
  logic                  pass_valid_q, pass_q;
  logic                  full, empty, push, pop;
  logic                  ev_bad, ev_dup, ev_miss, ev_ooseq;
  logic [3:0]            n_ev;
  logic [CNT_W+3:0]      sum;

  assign full  = (cnt_q == FullCnt);
  assign empty = (cnt_q == '0);
  // A pop frees the slot in the same cycle, so a push while full still lands.
  assign push  = EXP_VALID && (!full || ACT_VALID);
  assign pop   = ACT_VALID && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    cnt_d    = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= EXP_CMD;
  end

  // Descending scan leaves the lowest matching slot selected.
  always_comb begin
    sel = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (ROMID_TABLE[i*ROMID_W +: ROMID_W] == ROMID_IN) begin
        sel    = '0;
        sel[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    fcnt_d   = fcnt_q;
    ev_bad   = 1'b0;
    ev_dup   = 1'b0;
    ev_miss  = 1'b0;
    ev_ooseq = ROMID_VALID && (state_q != S_SRCH);
    if (ROMID_START) begin
      state_d = S_SRCH;
      mask_d  = '0;
      fcnt_d  = '0;
    end else begin
      case (state_q)
        S_SRCH: begin
          if (ROMID_VALID) begin
            if (sel == '0)             ev_bad = 1'b1;
            else if ((sel & mask_q) != '0) ev_dup = 1'b1;
            else                       mask_d = mask_q | sel;
            fcnt_d = fcnt_q + 1'b1;
            if (fcnt_d == NumSlv) state_d = S_CHECK;
          end
        end
        S_CHECK: begin
          ev_miss = !(&mask_q);
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign ev = {REPORT_REQ && !empty,
               ev_ooseq,
               STPZ_CHK && (STPZ != STPZ_EXP),
               ev_miss,
               ev_dup,
               ev_bad,
               EXP_VALID && full && !ACT_VALID,
               ACT_VALID && empty,
               pop && (mem_q[rd_ptr_q[AW-1:0]] != ACT_CMD)};

  always_comb begin
    n_ev = '0;
    for (int i = 0; i < 9; i++) n_ev = n_ev + {3'b0, ev[i]};
    flags_d = flags_q | ev;
    sum     = {4'b0, errcnt_q} + {{CNT_W{1'b0}}, n_ev};
    if (sum > {4'b0, {CNT_W{1'b1}}}) errcnt_d = '1;
    else                             errcnt_d = sum[CNT_W-1:0];
  end

  always_ff @(posedge CLK or negedge MRZ) begin
    if (!MRZ) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      state_q      <= S_IDLE;
      mask_q       <= '0;
      fcnt_q       <= '0;
      flags_q      <= '0;
      errcnt_q     <= '0;
      pass_valid_q <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      mask_q       <= mask_d;
      fcnt_q       <= fcnt_d;
      flags_q      <= flags_d;
      errcnt_q     <= errcnt_d;
      pass_valid_q <= REPORT_REQ;
      pass_q       <= REPORT_REQ && (flags_q == '0) && empty && (state_q == S_IDLE);
    end
  end

  assign EXP_FULL   = full;
  assign PASS_VALID = pass_valid_q;
  assign PASS       = pass_q;
  assign ERR_FLAGS  = flags_q;
  assign ERR_CNT    = errcnt_q;
  assign SRCH_BUSY  = (state_q != S_IDLE);

endmodule

// File: tb/tb_ow_scoreboard_chk.sv
// Directed bench for ow_scoreboard_chk with hand-computed expectations.
module tb_ow_scoreboard_chk;

  logic         CLK = 1'b0;
  logic         MRZ;
  logic         EXP_VALID, ACT_VALID, ROMID_START, ROMID_VALID;
  logic [7:0]   EXP_CMD, ACT_CMD;
  logic         EXP_FULL, PASS_VALID, PASS, SRCH_BUSY;
  logic [255:0] ROMID_TABLE;
  logic [63:0]  ROMID_IN;
  logic         STPZ, STPZ_CHK, STPZ_EXP, REPORT_REQ;
  logic [8:0]   ERR_FLAGS;
  logic [7:0]   ERR_CNT;

  int vec_n = 0;
  int mis_n = 0;

  localparam logic [63:0] Id0 = 64'h9507699504835129;
  localparam logic [63:0] Id1 = 64'h0879769580938271;
  localparam logic [63:0] Id2 = 64'h2597569559038281;
  localparam logic [63:0] Id3 = 64'h0879769534938291;

  ow_scoreboard_chk dut (
    .CLK(CLK), .MRZ(MRZ),
    .EXP_VALID(EXP_VALID), .EXP_CMD(EXP_CMD), .EXP_FULL(EXP_FULL),
    .ACT_VALID(ACT_VALID), .ACT_CMD(ACT_CMD),
    .ROMID_TABLE(ROMID_TABLE), .ROMID_START(ROMID_START),
    .ROMID_VALID(ROMID_VALID), .ROMID_IN(ROMID_IN),
    .STPZ(STPZ), .STPZ_CHK(STPZ_CHK), .STPZ_EXP(STPZ_EXP),
    .REPORT_REQ(REPORT_REQ), .PASS_VALID(PASS_VALID), .PASS(PASS),
    .ERR_FLAGS(ERR_FLAGS), .ERR_CNT(ERR_CNT), .SRCH_BUSY(SRCH_BUSY)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    EXP_VALID = 0; EXP_CMD = '0; ACT_VALID = 0; ACT_CMD = '0;
    ROMID_START = 0; ROMID_VALID = 0; ROMID_IN = '0;
    STPZ = 0; STPZ_CHK = 0; STPZ_EXP = 0; REPORT_REQ = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    ROMID_TABLE = {Id3, Id2, Id1, Id0};
    MRZ = 0;
    repeat (2) tick();
    MRZ = 1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    vec_n++; if (EXP_FULL !== 1'b0) begin mis_n++; $display("FAIL reset_full got %b exp 0", EXP_FULL); end
    vec_n++; if (PASS_VALID !== 1'b0 || PASS !== 1'b0) begin mis_n++;
      $display("FAIL reset_pass got %b/%b exp 0/0", PASS_VALID, PASS); end
    vec_n++; if (ERR_FLAGS !== 9'h000) begin mis_n++; $display("FAIL reset_flags got %h exp 000", ERR_FLAGS); end
    vec_n++; if (ERR_CNT !== 8'd0) begin mis_n++; $display("FAIL reset_cnt got %0d exp 0", ERR_CNT); end
    vec_n++; if (SRCH_BUSY !== 1'b0) begin mis_n++; $display("FAIL reset_busy got %b exp 0", SRCH_BUSY); end
  endtask

  task automatic test_cmd_match();
    logic [7:0] cmds [3] = '{8'h33, 8'hCC, 8'hF0};
    do_reset();
    for (int i = 0; i < 3; i++) begin EXP_VALID = 1; EXP_CMD = cmds[i]; tick(); end
    EXP_VALID = 0;
    for (int i = 0; i < 3; i++) begin ACT_VALID = 1; ACT_CMD = cmds[i]; tick(); end
    ACT_VALID = 0; REPORT_REQ = 1; tick(); REPORT_REQ = 0;
    vec_n++; if ({PASS_VALID, PASS} !== 2'b11) begin mis_n++;
      $display("FAIL match_verdict got %b exp 11", {PASS_VALID, PASS}); end
    vec_n++; if (ERR_FLAGS !== 9'h000 || ERR_CNT !== 8'd0) begin mis_n++;
      $display("FAIL match_flags got %h/%0d exp 000/0", ERR_FLAGS, ERR_CNT); end
    tick();
    vec_n++; if (PASS_VALID !== 1'b0) begin mis_n++; $display("FAIL match_strobe_len got %b exp 0", PASS_VALID); end
  endtask

  task automatic test_cmd_mismatch();
    do_reset();
    EXP_VALID = 1; EXP_CMD = 8'h33; tick(); EXP_VALID = 0;
    ACT_VALID = 1; ACT_CMD = 8'h55; tick();
    vec_n++; if (ERR_FLAGS !== 9'h001 || ERR_CNT !== 8'd1) begin mis_n++;
      $display("FAIL mismatch got %h/%0d exp 001/1", ERR_FLAGS, ERR_CNT); end
    ACT_CMD = 8'hCC; tick(); ACT_VALID = 0;
    vec_n++; if (ERR_FLAGS !== 9'h003 || ERR_CNT !== 8'd2) begin mis_n++;
      $display("FAIL unexpected got %h/%0d exp 003/2", ERR_FLAGS, ERR_CNT); end
    REPORT_REQ = 1; tick(); REPORT_REQ = 0;
    vec_n++; if ({PASS_VALID, PASS} !== 2'b10) begin mis_n++;
      $display("FAIL mismatch_verdict got %b exp 10", {PASS_VALID, PASS}); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 16; i++) begin EXP_VALID = 1; EXP_CMD = 8'(i); tick(); end
    vec_n++; if (EXP_FULL !== 1'b1 || ERR_FLAGS !== 9'h000) begin mis_n++;
      $display("FAIL full16 got %b/%h exp 1/000", EXP_FULL, ERR_FLAGS); end
    EXP_CMD = 8'hEE; tick();
    vec_n++; if (ERR_FLAGS !== 9'h004 || ERR_CNT !== 8'd1) begin mis_n++;
      $display("FAIL overflow got %h/%0d exp 004/1", ERR_FLAGS, ERR_CNT); end
    // Push and pop together while full; head is entry 0.
    EXP_CMD = 8'h10; ACT_VALID = 1; ACT_CMD = 8'h00; tick();
    EXP_VALID = 0;
    vec_n++; if (EXP_FULL !== 1'b1 || ERR_FLAGS !== 9'h004 || ERR_CNT !== 8'd1) begin mis_n++;
      $display("FAIL full_pushpop got %b/%h/%0d exp 1/004/1", EXP_FULL, ERR_FLAGS, ERR_CNT); end
    ACT_CMD = 8'h01; tick(); ACT_VALID = 0;
    vec_n++; if (EXP_FULL !== 1'b0 || ERR_FLAGS !== 9'h004) begin mis_n++;
      $display("FAIL after_pop got %b/%h exp 0/004", EXP_FULL, ERR_FLAGS); end
  endtask

  task automatic test_empty_pushpop();
    do_reset();
    EXP_VALID = 1; EXP_CMD = 8'h77; ACT_VALID = 1; ACT_CMD = 8'h77; tick(); EXP_VALID = 0;
    vec_n++; if (ERR_FLAGS !== 9'h002 || ERR_CNT !== 8'd1) begin mis_n++;
      $display("FAIL empty_pushpop got %h/%0d exp 002/1", ERR_FLAGS, ERR_CNT); end
    tick(); ACT_VALID = 0;
    REPORT_REQ = 1; tick(); REPORT_REQ = 0;
    vec_n++; if (ERR_FLAGS !== 9'h002 || ERR_CNT !== 8'd1 || {PASS_VALID, PASS} !== 2'b10) begin mis_n++;
      $display("FAIL landed_push got %h/%0d/%b exp 002/1/10", ERR_FLAGS, ERR_CNT, {PASS_VALID, PASS}); end
  endtask

  task automatic test_romid_ok();
    logic [63:0] ids [4] = '{Id3, Id2, Id1, Id0};
    do_reset();
    ROMID_START = 1; tick(); ROMID_START = 0;
    vec_n++; if (SRCH_BUSY !== 1'b1) begin mis_n++; $display("FAIL busy_rise got %b exp 1", SRCH_BUSY); end
    for (int i = 0; i < 4; i++) begin ROMID_VALID = 1; ROMID_IN = ids[i]; tick(); end
    ROMID_VALID = 0;
    vec_n++; if (SRCH_BUSY !== 1'b1) begin mis_n++; $display("FAIL busy_check got %b exp 1", SRCH_BUSY); end
    tick();
    vec_n++; if (SRCH_BUSY !== 1'b0 || ERR_FLAGS !== 9'h000) begin mis_n++;
      $display("FAIL romid_ok got %b/%h exp 0/000", SRCH_BUSY, ERR_FLAGS); end
    REPORT_REQ = 1; tick(); REPORT_REQ = 0;
    vec_n++; if ({PASS_VALID, PASS} !== 2'b11) begin mis_n++;
      $display("FAIL romid_verdict got %b exp 11", {PASS_VALID, PASS}); end
  endtask

  task automatic test_romid_err();
    logic [63:0] ids [4] = '{Id0, Id0, Id2, 64'h0};
    do_reset();
    ROMID_START = 1; tick(); ROMID_START = 0;
    for (int i = 0; i < 4; i++) begin ROMID_VALID = 1; ROMID_IN = ids[i]; tick(); end
    ROMID_VALID = 0;
    vec_n++; if (ERR_FLAGS !== 9'h018 || ERR_CNT !== 8'd2) begin mis_n++;
      $display("FAIL dup_invalid got %h/%0d exp 018/2", ERR_FLAGS, ERR_CNT); end
    tick();
    vec_n++; if (ERR_FLAGS !== 9'h038 || ERR_CNT !== 8'd3 || SRCH_BUSY !== 1'b0) begin mis_n++;
      $display("FAIL missing got %h/%0d/%b exp 038/3/0", ERR_FLAGS, ERR_CNT, SRCH_BUSY); end
    ROMID_VALID = 1; ROMID_IN = Id1; tick(); ROMID_VALID = 0;
    vec_n++; if (ERR_FLAGS !== 9'h0B8 || ERR_CNT !== 8'd4) begin mis_n++;
      $display("FAIL out_of_seq got %h/%0d exp 0b8/4", ERR_FLAGS, ERR_CNT); end
  endtask

  task automatic test_romid_dup_table();
    logic [63:0] ids [4] = '{Id0, Id0, Id1, Id3};
    do_reset();
    ROMID_TABLE = {Id3, Id0, Id1, Id0};
    ROMID_START = 1; tick(); ROMID_START = 0;
    for (int i = 0; i < 4; i++) begin ROMID_VALID = 1; ROMID_IN = ids[i]; tick(); end
    ROMID_VALID = 0; tick();
    vec_n++; if (ERR_FLAGS !== 9'h030 || ERR_CNT !== 8'd2) begin mis_n++;
      $display("FAIL lowest_wins got %h/%0d exp 030/2", ERR_FLAGS, ERR_CNT); end
  endtask

  task automatic test_romid_restart();
    logic [63:0] ids [4] = '{Id0, Id1, Id2, Id3};
    do_reset();
    ROMID_START = 1; tick(); ROMID_START = 0;
    ROMID_VALID = 1; ROMID_IN = Id0; tick(); ROMID_VALID = 0;
    ROMID_START = 1; tick(); ROMID_START = 0;
    for (int i = 0; i < 4; i++) begin ROMID_VALID = 1; ROMID_IN = ids[i]; tick(); end
    ROMID_VALID = 0; tick();
    vec_n++; if (ERR_FLAGS !== 9'h000 || SRCH_BUSY !== 1'b0) begin mis_n++;
      $display("FAIL restart got %h/%b exp 000/0", ERR_FLAGS, SRCH_BUSY); end
  endtask

  task automatic test_stpz_leftover();
    do_reset();
    STPZ = 1; STPZ_EXP = 0; STPZ_CHK = 0; tick();
    STPZ_EXP = 1; STPZ_CHK = 1; tick();
    vec_n++; if (ERR_FLAGS !== 9'h000) begin mis_n++; $display("FAIL stpz_ok got %h exp 000", ERR_FLAGS); end
    STPZ_EXP = 0; tick(); STPZ_CHK = 0;
    vec_n++; if (ERR_FLAGS !== 9'h040 || ERR_CNT !== 8'd1) begin mis_n++;
      $display("FAIL stpz_bad got %h/%0d exp 040/1", ERR_FLAGS, ERR_CNT); end
    EXP_VALID = 1; EXP_CMD = 8'hA5; tick(); EXP_VALID = 0;
    REPORT_REQ = 1; tick();
    vec_n++; if (ERR_FLAGS !== 9'h140 || ERR_CNT !== 8'd2 || {PASS_VALID, PASS} !== 2'b10) begin mis_n++;
      $display("FAIL leftover got %h/%0d/%b exp 140/2/10", ERR_FLAGS, ERR_CNT, {PASS_VALID, PASS}); end
    tick(); REPORT_REQ = 0;
    vec_n++; if (PASS_VALID !== 1'b1 || ERR_CNT !== 8'd3) begin mis_n++;
      $display("FAIL held_report got %b/%0d exp 1/3", PASS_VALID, ERR_CNT); end
  endtask

  task automatic test_multi_and_saturate();
    do_reset();
    ACT_VALID = 1; ACT_CMD = 8'h12; STPZ = 1; STPZ_EXP = 0; STPZ_CHK = 1;
    ROMID_VALID = 1; ROMID_IN = Id0; tick();
    vec_n++; if (ERR_FLAGS !== 9'h0C2 || ERR_CNT !== 8'd3) begin mis_n++;
      $display("FAIL multi_err got %h/%0d exp 0c2/3", ERR_FLAGS, ERR_CNT); end
    repeat (90) tick();
    idle_inputs();
    vec_n++; if (ERR_CNT !== 8'd255) begin mis_n++; $display("FAIL saturate got %0d exp 255", ERR_CNT); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    EXP_VALID = 1; EXP_CMD = 8'h44; ROMID_START = 1; tick();
    EXP_VALID = 0; ROMID_START = 0;
    ROMID_VALID = 1; ROMID_IN = 64'h1; REPORT_REQ = 1; tick();
    ROMID_VALID = 0; REPORT_REQ = 0;
    vec_n++; if (SRCH_BUSY !== 1'b1 || PASS_VALID !== 1'b1 || ERR_FLAGS !== 9'h108) begin mis_n++;
      $display("FAIL pre_reset got %b/%b/%h exp 1/1/108", SRCH_BUSY, PASS_VALID, ERR_FLAGS); end
    #2 MRZ = 0;
    #1;
    vec_n++; if ({SRCH_BUSY, PASS_VALID, PASS, EXP_FULL} !== 4'b0000 || ERR_FLAGS !== 9'h000 ||
                 ERR_CNT !== 8'd0) begin mis_n++;
      $display("FAIL async_reset got %b/%h/%0d exp 0000/000/0",
               {SRCH_BUSY, PASS_VALID, PASS, EXP_FULL}, ERR_FLAGS, ERR_CNT); end
    tick(); MRZ = 1; tick();
    REPORT_REQ = 1; tick(); REPORT_REQ = 0;
    vec_n++; if ({PASS_VALID, PASS} !== 2'b11) begin mis_n++;
      $display("FAIL post_reset_verdict got %b exp 11", {PASS_VALID, PASS}); end
  endtask

  initial begin
    test_reset();
    test_cmd_match();
    test_cmd_mismatch();
    test_overflow();
    test_empty_pushpop();
    test_romid_ok();
    test_romid_err();
    test_romid_dup_table();
    test_romid_restart();
    test_stpz_leftover();
    test_multi_and_saturate();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_n, mis_n);
    $finish;
  end

endmodule
